// File: rtl/carregador_relacoes.sv
// Host-side loader: packs MAX_VIZINHOS neighbour entries per node into one relations word
// and writes it with the node's obstacle bit. Optional macro: CARREGADOR_CHECKSUM_EN.
module carregador_relacoes #(
    parameter int ADDR_WIDTH          = 10,
    parameter int CUSTO_WIDTH         = 4,
    parameter int MAX_VIZINHOS        = 8,
    parameter int UMA_RELACAO_WIDTH   = ADDR_WIDTH + CUSTO_WIDTH,
    parameter int RELACOES_DATA_WIDTH = MAX_VIZINHOS * UMA_RELACAO_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           host_iniciar_in,
    input  logic [ADDR_WIDTH-1:0]          host_num_nos_in,
    input  logic                           host_valid_in,
    input  logic [UMA_RELACAO_WIDTH-1:0]   host_data_in,
    input  logic                           host_obstaculo_in,
    output logic                           host_ready_out,
    output logic                           relacoes_wr_en_out,
    output logic [ADDR_WIDTH-1:0]          relacoes_wr_addr_out,
    output logic [RELACOES_DATA_WIDTH-1:0] relacoes_wr_data_out,
    output logic                           obstaculos_wr_en_out,
    output logic [ADDR_WIDTH-1:0]          obstaculos_wr_addr_out,
    output logic                           obstaculos_wr_data_out,
    output logic                           carregando_out,
    output logic                           pronto_out,
    output logic                           erro_out
`ifdef CARREGADOR_CHECKSUM_EN
    ,
    input  logic [UMA_RELACAO_WIDTH-1:0]   host_checksum_in,
    output logic [UMA_RELACAO_WIDTH-1:0]   checksum_out
`endif
);

    localparam int SLOT_W = (MAX_VIZINHOS > 1) ? $clog2(MAX_VIZINHOS) : 1;
    localparam logic [SLOT_W-1:0] ULTIMO_SLOT = SLOT_W'(MAX_VIZINHOS - 1);

    typedef enum logic [1:0] {OCIOSO, RECEBER, ESCREVER, CONCLUIDO} estado_t;

    estado_t estado, prox;

    logic [ADDR_WIDTH-1:0]          num_nos;
    logic [ADDR_WIDTH-1:0]          no_atual;
    logic [SLOT_W-1:0]              slot;
    logic [RELACOES_DATA_WIDTH-1:0] pack, pack_prox;
    logic                           obst_lat, obst_prox;
    logic                           aceito, ultimo_beat, ultimo_no, inicio_ok;

    // Acceptance is derived from state, not from host_ready_out, to keep the FSM comb acyclic.
    assign aceito      = host_valid_in && (estado == RECEBER);
    assign ultimo_beat = aceito && (slot == ULTIMO_SLOT);
    assign ultimo_no   = (no_atual == num_nos - ADDR_WIDTH'(1));
    assign inicio_ok   = host_iniciar_in && (estado == OCIOSO || estado == CONCLUIDO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox;
    end

    always_comb begin
        prox           = estado;
        host_ready_out = 1'b0;
        carregando_out = 1'b0;
        pronto_out     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (host_iniciar_in)
                    prox = (host_num_nos_in == '0) ? CONCLUIDO : RECEBER;
            end
            RECEBER: begin
                host_ready_out = 1'b1;
                carregando_out = 1'b1;
                if (host_valid_in && slot == ULTIMO_SLOT) prox = ESCREVER;
            end
            ESCREVER: begin
                carregando_out = 1'b1;
                prox = ultimo_no ? CONCLUIDO : RECEBER;
            end
            CONCLUIDO: begin
                pronto_out = 1'b1;
                if (host_iniciar_in)
                    prox = (host_num_nos_in == '0) ? CONCLUIDO : RECEBER;
            end
            default: prox = OCIOSO;
        endcase
    end

    always_comb begin
        pack_prox = pack;
        for (int i = 0; i < MAX_VIZINHOS; i++)
            if (slot == SLOT_W'(i))
                pack_prox[i*UMA_RELACAO_WIDTH +: UMA_RELACAO_WIDTH] = host_data_in;
        obst_prox = (slot == '0) ? host_obstaculo_in : obst_lat;
    end

`ifdef CARREGADOR_CHECKSUM_EN
    logic [UMA_RELACAO_WIDTH-1:0] soma;
    assign checksum_out = soma;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         soma <= '0;
        else if (inicio_ok) soma <= '0;
        else if (aceito)    soma <= soma ^ host_data_in;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_nos                <= '0;
            no_atual               <= '0;
            slot                   <= '0;
            pack                   <= '0;
            obst_lat               <= 1'b0;
            erro_out               <= 1'b0;
            relacoes_wr_en_out     <= 1'b0;
            relacoes_wr_addr_out   <= '0;
            relacoes_wr_data_out   <= '0;
            obstaculos_wr_en_out   <= 1'b0;
            obstaculos_wr_addr_out <= '0;
            obstaculos_wr_data_out <= 1'b0;
        end else begin
            relacoes_wr_en_out   <= 1'b0;
            obstaculos_wr_en_out <= 1'b0;

            if (inicio_ok) begin
                num_nos  <= host_num_nos_in;
                no_atual <= '0;
                slot     <= '0;
                erro_out <= 1'b0;
            end else if (host_iniciar_in) begin
                erro_out <= 1'b1;
            end

            if (aceito) begin
                pack     <= pack_prox;
                obst_lat <= obst_prox;
                slot     <= ultimo_beat ? '0 : slot + SLOT_W'(1);
            end

            // Registered write port: loaded on the last beat, so the strobe lands in ESCREVER.
            if (ultimo_beat) begin
                relacoes_wr_en_out     <= 1'b1;
                obstaculos_wr_en_out   <= 1'b1;
                relacoes_wr_addr_out   <= no_atual;
                obstaculos_wr_addr_out <= no_atual;
                relacoes_wr_data_out   <= pack_prox;
                obstaculos_wr_data_out <= obst_prox;
            end

            if (estado == ESCREVER && !ultimo_no)
                no_atual <= no_atual + ADDR_WIDTH'(1);

`ifdef CARREGADOR_CHECKSUM_EN
            if (estado == ESCREVER && ultimo_no && host_checksum_in != soma)
                erro_out <= 1'b1;
            if (inicio_ok && host_num_nos_in == '0 && host_checksum_in != '0)
                erro_out <= 1'b1;
`endif
        end
    end

endmodule
